// File: rtl/dds_wave_gen.sv
// Direct digital synthesiser: phase accumulator, phase offset, sine ROM, gain, DC bias with saturation.
// Optional build macro DDS_PHASE_DITHER_EN adds LFSR phase dither ahead of LUT address truncation.
module dds_wave_gen #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 10,
    parameter int DATA_W  = 10,
    parameter int DC_BIAS = 512
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [PHASE_W-1:0] i_freq_word,
    input  logic               i_freq_valid,
    output logic               o_freq_ready,
    input  logic [PHASE_W-1:0] i_phase_offs,
    input  logic [7:0]         i_amp,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_data_valid,
    output logic               o_sync
);

    localparam int LUT_SIZE = 1 << LUT_AW;
    localparam int SMP_W    = 10;
    localparam int PROD_W   = SMP_W + 9;
    localparam int SCL_W    = PROD_W - 7;
    localparam int SUM_W    = ((SCL_W > DATA_W) ? SCL_W : DATA_W) + 2;
    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((1 << DATA_W) - 1);

    // ------------------------------------------------------------------
    // Sine table, fully resolved at elaboration.
    // ------------------------------------------------------------------
    function automatic logic signed [SMP_W-1:0] sine_entry(input int k);
        real v;
        int  r;
        v = real'((1 << (SMP_W - 1)) - 1)
            * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_SIZE));
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return r[SMP_W-1:0];
    endfunction

    // NOTE: the table is pure constant logic; only the registered read port below carries reset.
    logic signed [SMP_W-1:0] sine_lut [LUT_SIZE];
    for (genvar k = 0; k < LUT_SIZE; k++) begin : g_lut
        assign sine_lut[k] = sine_entry(k);
    end

    // ------------------------------------------------------------------
    // Stage 0: accumulator and phase-continuous frequency handshake
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] word_q, word_d;
    logic [PHASE_W-1:0] pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic               v0_q, wrap0_q, wrap0_d;
    logic [PHASE_W-1:0] acc_sum;
    logic               carry;
    logic               step;
    logic               accept;
    logic               apply;

    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, word_q};

    // The first enabled cycle emits phase 0; stepping starts on the cycle after.
    assign step   = i_en & v0_q;
    assign accept = i_freq_valid & ~pend_vld_q;
    assign apply  = pend_vld_q & (i_en ? (step & carry) : 1'b1);

    // NOTE: every _d gets its default before any condition, so no path can infer a latch.
    always_comb begin
        acc_d      = '0;
        wrap0_d    = 1'b0;
        word_d     = word_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (step) begin
            acc_d   = acc_sum;
            wrap0_d = carry;
        end
        if (apply) begin
            word_d     = pend_q;
            pend_vld_d = 1'b0;
        end else if (accept) begin
            pend_d     = i_freq_word;
            pend_vld_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            word_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            v0_q       <= 1'b0;
            wrap0_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            word_q     <= word_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            v0_q       <= i_en;
            wrap0_q    <= wrap0_d;
        end
    end

    assign o_freq_ready = ~pend_vld_q;

    // ------------------------------------------------------------------
    // Stage 1: phase offset (plus optional dither) and address truncation
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0] phase;

`ifdef DDS_PHASE_DITHER_EN
    localparam logic [PHASE_W-1:0] DITH_MASK = {PHASE_W{1'b1}} >> LUT_AW;
    logic [15:0] lfsr_q, lfsr_d;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    always_comb begin
        lfsr_d = lfsr_q;
        if (i_en) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign phase = acc_q + i_phase_offs + (PHASE_W'(lfsr_q) & DITH_MASK);
`else
    assign phase = acc_q + i_phase_offs;
`endif

    logic [LUT_AW-1:0] addr_d, addr_q;
    assign addr_d = LUT_AW'(phase >> (PHASE_W - LUT_AW));

    // ------------------------------------------------------------------
    // Stages 2-4: ROM read, gain, bias and saturation
    // ------------------------------------------------------------------
    logic signed [SMP_W-1:0]  rom_q;
    logic signed [8:0]        amp_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [SCL_W-1:0]  scaled_d, scaled_q;
    logic signed [SUM_W-1:0]  biased;
    logic [DATA_W-1:0]        data_d, data_q;
    logic                     v1_q, v2_q, v3_q, valid_q;
    logic                     s1_q, s2_q, s3_q, sync_q;

    assign amp_s    = $signed({1'b0, i_amp});
    assign prod     = PROD_W'(rom_q) * PROD_W'(amp_s);
    assign scaled_d = SCL_W'(prod >>> 7);
    assign biased   = SUM_W'(scaled_q) + SUM_W'(DC_BIAS);

    // Invalid slots present mid-scale so the DAC idles quietly while flushing.
    always_comb begin
        data_d = DATA_W'(DC_BIAS);
        if (v3_q) begin
            if (biased[SUM_W-1]) begin
                data_d = '0;
            end else if (biased > OUT_MAX) begin
                data_d = '1;
            end else begin
                data_d = DATA_W'(biased);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            rom_q    <= '0;
            scaled_q <= '0;
            data_q   <= DATA_W'(DC_BIAS);
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            valid_q  <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            rom_q    <= sine_lut[addr_q];
            scaled_q <= scaled_d;
            data_q   <= data_d;
            v1_q     <= v0_q;
            v2_q     <= v1_q;
            v3_q     <= v2_q;
            valid_q  <= v3_q;
            s1_q     <= wrap0_q & v0_q;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            sync_q   <= s3_q & v3_q;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_sync       = sync_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: a reference model pushes expected samples as stimulus is driven,
// a monitor pops and compares them when the generator presents valid output.
`timescale 1ns/1ps
module tb_dds_wave_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic [31:0] i_freq_word = '0;
    logic        i_freq_valid = 1'b0;
    logic        o_freq_ready;
    logic [31:0] i_phase_offs = '0;
    logic [7:0]  i_amp = 8'd128;
    logic [9:0]  o_data;
    logic        o_data_valid;
    logic        o_sync;

    always #5 clk = ~clk;

    dds_wave_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (i_en),
        .i_freq_word (i_freq_word),
        .i_freq_valid(i_freq_valid),
        .o_freq_ready(o_freq_ready),
        .i_phase_offs(i_phase_offs),
        .i_amp       (i_amp),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .o_sync      (o_sync)
    );

    typedef struct {
        int data;
        bit sync;
        int stamp;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    logic [31:0] m_acc = '0;
    logic [31:0] m_word = '0;
    logic [31:0] m_pend = '0;
    bit          m_pend_v = 1'b0;
    bit          m_run = 1'b0;

    int          obs_max, obs_min, first_data, last_sync, sync_gap, sync_cnt;
    bit          prev_valid = 1'b0;
    exp_t        mon_e;

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int ref_sine(input int k);
        real v;
        v = 511.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
        return int'($floor(v + 0.5));
    endfunction

    function automatic int exp_sample(input logic [31:0] acc, input logic [31:0] offs, input int amp);
        logic [31:0] ph;
        int          p;
        int          y;
        ph = acc + offs;
        p  = ref_sine(int'(ph[31:22])) * amp;
        y  = (p >>> 7) + 512;
        if (y < 0) y = 0;
        if (y > 1023) y = 1023;
        return y;
    endfunction

    // Reference behaviour for the upcoming rising edge, given the inputs just driven.
    task automatic model_edge();
        logic [32:0] sum;
        bit          carry;
        exp_t        e;
        carry = 1'b0;
        if (i_en) begin
            if (!m_run) begin
                m_acc = '0;
                m_run = 1'b1;
            end else begin
                sum   = {1'b0, m_acc} + {1'b0, m_word};
                carry = sum[32];
                m_acc = sum[31:0];
            end
            e.data  = exp_sample(m_acc, i_phase_offs, int'(i_amp));
            e.sync  = carry;
            e.stamp = cyc + 1;
            sb.push_back(e);
        end else begin
            m_run = 1'b0;
            m_acc = '0;
        end
        if (m_pend_v && (carry || !i_en)) begin
            m_word   = m_pend;
            m_pend_v = 1'b0;
        end else if (i_freq_valid && !m_pend_v) begin
            m_pend   = i_freq_word;
            m_pend_v = 1'b1;
        end
    endtask

    task automatic step(input bit en, input bit fv, input logic [31:0] fw);
        @(negedge clk);
        i_en         = en;
        i_freq_valid = fv;
        i_freq_word  = fw;
        model_edge();
    endtask

    task automatic clear_stats();
        obs_max    = -1;
        obs_min    = 1 << 30;
        first_data = -1;
        last_sync  = -1;
        sync_gap   = -1;
        sync_cnt   = 0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples 1 ns after the active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (o_data_valid) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("data", int'(o_data), mon_e.data);
                    check("sync", int'(o_sync), int'(mon_e.sync));
                    check("latency", cyc - mon_e.stamp, 4);
                end
                if (int'(o_data) > obs_max) obs_max = int'(o_data);
                if (int'(o_data) < obs_min) obs_min = int'(o_data);
                if (!prev_valid) first_data = int'(o_data);
                if (o_sync) begin
                    if (last_sync >= 0) sync_gap = cyc - last_sync;
                    last_sync = cyc;
                    sync_cnt++;
                end
            end else begin
                check("idle_data", int'(o_data), 512);
                check("idle_sync", int'(o_sync), 0);
            end
            check("ready", int'(o_freq_ready), int'(!m_pend_v));
            prev_valid = o_data_valid;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_data", int'(o_data), 512);
        check("rst_valid", int'(o_data_valid), 0);
        check("rst_sync", int'(o_sync), 0);
        check("rst_ready", int'(o_freq_ready), 1);
        rst_n = 1'b1;

        // Load 2^22 while disabled: applied on the cycle after acceptance.
        step(1'b0, 1'b1, 32'h0040_0000);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        // Unity gain, 1024-sample period.
        clear_stats();
        repeat (2100) step(1'b1, 1'b0, '0);
        check("t1_first", first_data, 512);
        check("t1_peak", obs_max, 1023);
        check("t1_trough", obs_min, 1);
        check("t1_sync_gap", sync_gap, 1024);

        // Full gain saturates cleanly at both rails.
        repeat (8) step(1'b0, 1'b0, '0);
        i_amp = 8'd255;
        clear_stats();
        repeat (1100) step(1'b1, 1'b0, '0);
        check("t2_peak", obs_max, 1023);
        check("t2_trough", obs_min, 0);

        // Zero gain holds mid-scale.
        repeat (8) step(1'b0, 1'b0, '0);
        i_amp = 8'd0;
        clear_stats();
        repeat (40) step(1'b1, 1'b0, '0);
        check("t3_max", obs_max, 512);
        check("t3_min", obs_min, 512);

        // Mid-period frequency change, ignored word while busy, then a fresh accept.
        repeat (8) step(1'b0, 1'b0, '0);
        i_amp = 8'd128;
        clear_stats();
        repeat (1300) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0080_0000);
        #6;
        check("t4_ready_drop", int'(o_freq_ready), 0);
        repeat (20) step(1'b1, 1'b1, 32'h0020_0000);
        repeat (1600) step(1'b1, 1'b0, '0);
        check("t4_sync_gap", sync_gap, 512);
        check("t4_ready_back", int'(o_freq_ready), 1);
        step(1'b1, 1'b1, 32'h0040_0000);
        repeat (1100) step(1'b1, 1'b0, '0);

        // Quarter-cycle offset, then asynchronous reset with a word pending.
        repeat (8) step(1'b0, 1'b0, '0);
        i_phase_offs = 32'h4000_0000;
        clear_stats();
        repeat (10) step(1'b1, 1'b0, '0);
        check("t5_first", first_data, 1023);
        step(1'b1, 1'b1, 32'h0080_0000);
        repeat (3) step(1'b1, 1'b0, '0);
        @(posedge clk);
        #3;
        rst_n        = 1'b0;
        i_en         = 1'b0;
        i_freq_valid = 1'b0;
        #1;
        check("arst_data", int'(o_data), 512);
        check("arst_valid", int'(o_data_valid), 0);
        check("arst_sync", int'(o_sync), 0);
        check("arst_ready", int'(o_freq_ready), 1);
        sb.delete();
        m_acc    = '0;
        m_word   = '0;
        m_pend   = '0;
        m_pend_v = 1'b0;
        m_run    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Word 0 after reset: constant sin(offset) output, never a sync.
        clear_stats();
        repeat (30) step(1'b1, 1'b0, '0);
        check("t6_max", obs_max, 1023);
        check("t6_min", obs_min, 1023);
        check("t6_no_sync", sync_cnt, 0);

        repeat (8) step(1'b0, 1'b0, '0);
        check("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
